// File: rtl/rand_pkg.sv
// Shared definitions for the rand_ser serializer: FSM state encoding and
// default geometry (word width, clocks per serial bit).
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int WS_DEF  = 16;
    localparam int DIV_DEF = 4;

endpackage

// File: rtl/rand_tick.sv
// Bit-period divider: free-running 0..DIV-1 counter that restarts on clear.
// tick is high on the last cycle of each period; with DIV=1 it is always high.
module rand_tick
    import rand_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Period counter; a load restarts the period so bit 0 gets a full DIV cycles
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/rand_ser.sv
// rand_ser: parallel-to-serial transmitter with a one-word holding register
// in front of the shift register, LSB first, DIV clocks per bit.
// Optional feature: define RAND_SER_PARITY_EN to append an even-parity bit
// after bit ws-1 of every word.
module rand_ser
    import rand_pkg::*;
#(
    parameter int ws  = WS_DEF,
    parameter int DIV = DIV_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [ws-1:0] iData,
    input  logic          iValid,
    output logic          oReady,
    output logic          oOut,
    output logic          oStrobe,
    output logic          oFrame
);

    localparam int BW = $clog2(ws);
    localparam logic [BW-1:0] LAST_BIT = BW'(ws - 1);

    state_t        state;
    logic [ws-1:0] hold;
    logic          holdFull;
    logic [ws-2:0] shReg;      // bits still to send; bit 0 is already on oOut
    logic [BW-1:0] bitIdx;
    logic          tick;
    logic          accept;
    logic          frameEnd;
    logic          loadNow;
`ifdef RAND_SER_PARITY_EN
    logic          parBit;
`endif

    assign oReady  = ~holdFull;
    assign accept  = iValid & ~holdFull;
    // oFrame gates the free-running tick so strobes only appear inside a frame
    assign oStrobe = tick & oFrame;

`ifdef RAND_SER_PARITY_EN
    assign frameEnd = tick && (state == PARITY);
`else
    assign frameEnd = tick && (state == SHIFT) && (bitIdx == LAST_BIT);
`endif

    // Holding-to-shift transfer: from IDLE at once, or seamlessly at frame end
    assign loadNow = holdFull && ((state == IDLE) || frameEnd);

    rand_tick #(.DIV(DIV)) uTick (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .clear (loadNow),
        .tick  (tick)
    );

    // Holding register; accept and transfer never coincide since accept needs it empty
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hold     <= '0;
            holdFull <= 1'b0;
        end else if (accept) begin
            hold     <= iData;
            holdFull <= 1'b1;
        end else if (loadNow) begin
            holdFull <= 1'b0;
        end
    end

    // Transmit FSM with registered oOut/oFrame; a load overrides the end-of-frame idle
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            shReg  <= '0;
            bitIdx <= '0;
            oOut   <= 1'b0;
            oFrame <= 1'b0;
`ifdef RAND_SER_PARITY_EN
            parBit <= 1'b0;
`endif
        end else if (loadNow) begin
            state  <= SHIFT;
            shReg  <= hold[ws-1:1];
            bitIdx <= '0;
            oOut   <= hold[0];
            oFrame <= 1'b1;
`ifdef RAND_SER_PARITY_EN
            parBit <= ^hold;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (tick) begin
                        if (bitIdx == LAST_BIT) begin
`ifdef RAND_SER_PARITY_EN
                            state <= PARITY;
                            oOut  <= parBit;
`else
                            state  <= IDLE;
                            oOut   <= 1'b0;
                            oFrame <= 1'b0;
`endif
                        end else begin
                            bitIdx <= bitIdx + BW'(1);
                            oOut   <= shReg[0];
                            shReg  <= shReg >> 1;
                        end
                    end
                end
`ifdef RAND_SER_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state  <= IDLE;
                        oOut   <= 1'b0;
                        oFrame <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_ser.sv
// Self-checking bench for rand_ser: a scoreboard expands every accepted word
// into its expected per-cycle (oOut, oStrobe) waveform and compares each frame
// cycle; directed scenarios check latency, frame length, flow control, reset
// abort and the DIV=1 case on a second instance.
module tb_rand_ser;

    localparam int WS = 16;
    localparam int DV = 4;
`ifdef RAND_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (WS + PAR) * DV;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic [WS-1:0] iData = '0;
    logic          iValid = 1'b0;
    logic          oReady, oOut, oStrobe, oFrame;

    logic [WS-1:0] d1Data = '0;
    logic          d1Valid = 1'b0;
    logic          d1Ready, d1Out, d1Strobe, d1Frame;

    int checks = 0;
    int failures = 0;

    logic [1:0]    expQ[$];
    logic          capBits[$];
    int            runLen = 0, stbCnt = 0, lastRun = 0, lastStb = 0;
    logic [WS-1:0] lastWord = '0;
    logic          lastPar = 1'b0;

    rand_ser #(.ws(WS), .DIV(DV)) dut (
        .iCLK(iCLK), .iRST(iRST), .iData(iData), .iValid(iValid),
        .oReady(oReady), .oOut(oOut), .oStrobe(oStrobe), .oFrame(oFrame)
    );

    rand_ser #(.ws(WS), .DIV(1)) dut1 (
        .iCLK(iCLK), .iRST(iRST), .iData(d1Data), .iValid(d1Valid),
        .oReady(d1Ready), .oOut(d1Out), .oStrobe(d1Strobe), .oFrame(d1Frame)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected waveform of one frame: each bit held DV cycles, strobe on the last
    task automatic pushWord(input logic [WS-1:0] w);
        for (int b = 0; b < WS + PAR; b++) begin
            logic bv;
            bv = (b < WS) ? w[b] : ^w;
            for (int d = 0; d < DV; d++)
                expQ.push_back({bv, (d == DV - 1) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic monClear();
        expQ.delete();
        capBits.delete();
        runLen = 0;
        stbCnt = 0;
    endtask

    // Scoreboard: record accepts at the clock edge, compare outputs mid-cycle
    task automatic monitor();
        forever begin
            @(posedge iCLK);
            if (iRST) monClear();
            else if (iValid && oReady) pushWord(iData);
            @(negedge iCLK);
            if (iRST) begin
                monClear();
            end else if (oFrame) begin
                if (expQ.size() == 0) chk("extraFrameCycle", 1, 0);
                else chk("outStb", {30'd0, oOut, oStrobe}, {30'd0, expQ.pop_front()});
                runLen++;
                if (oStrobe) begin
                    stbCnt++;
                    capBits.push_back(oOut);
                end
            end else begin
                chk("idleOutStb", {30'd0, oOut, oStrobe}, 0);
                if (runLen != 0) begin
                    lastRun = runLen;
                    lastStb = stbCnt;
                    for (int i = 0; i < WS; i++)
                        lastWord[i] = (capBits.size() > i) ? capBits[i] : 1'b0;
                    lastPar = (capBits.size() > WS) ? capBits[WS] : 1'b0;
                    runLen = 0;
                    stbCnt = 0;
                    capBits.delete();
                end
            end
        end
    endtask

    // Present a word and hold it until accepted; rl = frame run length seen when ready
    task automatic sendWord(input logic [WS-1:0] w, output int rl);
        int n;
        n = 0;
        @(negedge iCLK); #1;
        iData = w;
        iValid = 1'b1;
        while (!oReady && n < 500) begin
            @(negedge iCLK); #1;
            n++;
        end
        rl = runLen;
        if (!oReady) chk("acceptTimeout", 0, 1);
        @(posedge iCLK); #1;
        iValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || oFrame || !oReady) && n < 3000) begin
            @(negedge iCLK); #1;
            n++;
        end
        chk("idleTimeout", (n < 3000) ? 1 : 0, 1);
        @(negedge iCLK); #1;
    endtask

    initial begin
        int rl, n, fcnt, scnt, srun, smax;
        logic [WS-1:0] w, capW;
        logic capP;

        fork
            monitor();
        join_none

        // Reset state, asserted before any clock edge
        #2;
        chk("rstReady", oReady, 1);
        chk("rstOut", oOut, 0);
        chk("rstFrame", oFrame, 0);
        chk("rstStrobe", oStrobe, 0);
        chk("rstReady1", d1Ready, 1);
        @(negedge iCLK); #1;
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);

        // Single word, with load latency: frame starts the cycle after the transfer edge
        sendWord(16'hA5C3, rl);
        @(negedge iCLK); #1;
        chk("latFrameLow", oFrame, 0);
        @(negedge iCLK); #1;
        chk("latFrameHigh", oFrame, 1);
        chk("latBit0", oOut, 1);
        waitIdle();
        chk("a5c3Word", lastWord, 16'hA5C3);
        chk("a5c3Strobes", lastStb, WS + PAR);
        chk("a5c3Run", lastRun, FL);

        // Two words back to back: one unbroken frame
        sendWord(16'h1234, rl);
        sendWord(16'hFFFF, rl);
        waitIdle();
        chk("b2bRun", lastRun, 2 * FL);
        chk("b2bStrobes", lastStb, 2 * (WS + PAR));
        chk("b2bWord1", lastWord, 16'h1234);

        // Three words: second one stalls the holding register until the first reload
        sendWord(16'h0F0F, rl);
        sendWord(16'h5A5A, rl);
        chk("rdyLowAfter2", oReady, 0);
        sendWord(16'hC001, rl);
        chk("rdyRiseAtReload", rl, FL + 1);
        waitIdle();
        chk("threeRun", lastRun, 3 * FL);
        chk("threeWord1", lastWord, 16'h0F0F);

        // Reset in the middle of bit 7, then a clean word
        sendWord(16'hFFFF, rl);
        n = 0;
        while (runLen != 7 * DV + 2 && n < 200) begin
            @(negedge iCLK); #1;
            n++;
        end
        chk("reachBit7", runLen, 7 * DV + 2);
        iRST = 1'b1;
        #1;
        chk("abortOut", oOut, 0);
        chk("abortFrame", oFrame, 0);
        chk("abortReady", oReady, 1);
        chk("abortStrobe", oStrobe, 0);
        @(posedge iCLK);
        @(negedge iCLK); #1;
        iRST = 1'b0;
        sendWord(16'h0003, rl);
        waitIdle();
        chk("postRstWord", lastWord, 16'h0003);
        chk("postRstRun", lastRun, FL);

        // Parity corner words (parity bit expected only when the feature is built in)
        sendWord(16'h0001, rl);
        waitIdle();
        chk("w0001Run", lastRun, FL);
        chk("w0001Par", lastPar, (PAR != 0) ? 1 : 0);
        sendWord(16'h0003, rl);
        waitIdle();
        chk("w0003Par", lastPar, 0);

        // Randomized traffic with random gaps between offers
        for (int k = 0; k < 14; k++) begin
            w = 16'($urandom);
            sendWord(w, rl);
            repeat ($urandom_range(0, 2) * ((k % 3 == 0) ? 40 : 1)) @(negedge iCLK);
        end
        waitIdle();
        chk("queueDrained", expQ.size(), 0);

        // DIV=1 instance: strobe every frame cycle
        @(negedge iCLK); #1;
        d1Data = 16'h8001;
        d1Valid = 1'b1;
        @(posedge iCLK); #1;
        d1Valid = 1'b0;
        fcnt = 0; scnt = 0; srun = 0; smax = 0; capW = '0; capP = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge iCLK); #1;
            if (d1Frame) begin
                if (fcnt < WS) capW[fcnt] = d1Out;
                else capP = d1Out;
                fcnt++;
            end
            if (d1Strobe) begin
                scnt++;
                srun++;
                if (srun > smax) smax = srun;
            end else begin
                srun = 0;
            end
        end
        chk("div1Frame", fcnt, WS + PAR);
        chk("div1Strobes", scnt, WS + PAR);
        chk("div1StrobeRun", smax, WS + PAR);
        chk("div1Word", capW, 16'h8001);
        chk("div1Par", capP, 0);
        chk("div1Idle", {d1Frame, d1Out, d1Ready}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rand_ser.md
RAND_SER -- requirements
Module: rand_ser

Interface
REQ-001 SHALL have parameter ws, default 16, meaning the parallel word width in bits (ws >= 2).
REQ-002 SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (DIV >= 1).
REQ-003 SHALL have port iCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port iRST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port iData  input  ws  parallel word to transmit.
REQ-006 SHALL have port iValid  input  1  iData valid; held with iData stable until accepted.
REQ-007 SHALL have port oReady  output  1  holding register empty; a word is accepted on an edge where iValid && oReady.
REQ-008 SHALL have port oOut  output  1  serial data bit, registered.
REQ-009 SHALL have port oStrobe  output  1  one-cycle pulse on the last cycle of each bit period; this is the receiver sample point.
REQ-010 SHALL have port oFrame  output  1  high for every cycle a word (or its parity bit) is being driven on oOut.

Function
REQ-011 SHALL buffer up to two words: one holding register and one shift register.
REQ-012 SHALL transfer holding to shift register on the edge after holding fills when state is IDLE; bit 0 appears on oOut in the following cycle.
REQ-013 SHALL transmit LSB first, each bit driven for exactly DIV cycles, with oStrobe high on the DIV-th cycle.
REQ-014 SHALL implement states IDLE -> SHIFT (on load) -> IDLE after bit ws-1 completes when holding is empty, or reload without leaving SHIFT when holding is full.
REQ-015 SHALL send back-to-back words with zero idle cycles: bit 0 of the next word follows bit ws-1 of the current word on the next cycle.
REQ-016 SHALL, on a simultaneous accept and holding-to-shift transfer in one edge, leave holding full with the new word and oReady low.
REQ-017 SHALL ignore iValid while oReady is low; no word is dropped or duplicated.
REQ-018 SHALL keep a bit-period counter (0..DIV-1) and a bit-index counter (0..ws-1) that both clear on every shift-register load; with DIV=1 oStrobe is high every cycle of the frame.
REQ-019 SHALL drive oOut low and oFrame low in IDLE.

Reset
REQ-020 SHALL, while iRST is high and independent of iCLK, force state IDLE, both registers empty, oOut=0, oStrobe=0, oFrame=0, oReady=1, and both counters to 0.
REQ-021 SHALL abort a word in progress on reset mid-frame with no partial completion; after release, the first transmitted word is the next accepted word.

Configuration
REQ-022 SHALL, with macro RAND_SER_PARITY_EN defined, add state PARITY after bit ws-1 that drives the even-parity bit (XOR of all ws data bits) for DIV cycles with oStrobe and oFrame asserted, and perform the reload/IDLE decision of REQ-014 at the end of PARITY.
REQ-023 SHALL, without RAND_SER_PARITY_EN, contain no parity logic; frame length is exactly ws*DIV cycles.

Structure
REQ-024 SHALL place the state enumeration (IDLE, SHIFT, PARITY) and the default values of ws and DIV in shared package rand_pkg.
REQ-025 SHALL implement the bit-period divider as sub-module rand_tick (inputs iCLK, iRST, clear; output one-cycle tick every DIV cycles).

Verification
REQ-026 SHALL cover: ws=16, DIV=4, send 16'hA5C3 -> oOut 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, 4 cycles per bit, 16 strobes, oFrame high 64 cycles.
REQ-027 SHALL cover: 16'h1234 then 16'hFFFF with iValid held -> oFrame continuously high 128 cycles, no gap between bit 15 of word 1 and bit 0 of word 2.
REQ-028 SHALL cover: three words presented back-to-back -> oReady low after the second word is accepted until the first word's shift-register reload; all three words are transmitted in order.
REQ-029 SHALL cover: iRST pulsed at bit 7 of 16'hFFFF -> oOut=0, oFrame=0, oReady=1 immediately; the next word 16'h0003 is transmitted intact.
REQ-030 SHALL cover: with RAND_SER_PARITY_EN, send 16'h0001 -> 17th bit = 1, oFrame high 68 cycles; send 16'h0003 -> 17th bit = 0.
REQ-031 SHALL cover: DIV=1, send 16'h8001 -> oStrobe high 16 consecutive cycles, oOut 1 then fourteen 0s then 1.
